// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM pipeline stages, the arbiter and the
// unified memory. The arbiter uses the slave view; the pipeline/memory side
// uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and
// load/store (DM). DM wins ties unless IF has lost STARVE_MAX ties in a row.
// A requester whose ready pulse is high is still holding its old request,
// so it is not considered in that cycle.
// Optional feature macro: ARB_STATS_EN adds stat_conflict / stat_forced.
//
// state   | meaning
// IDLE    | no access in flight, arbitrating
// IF_BUSY | fetch access issued, waiting for mem_ack
// DM_BUSY | load/store access issued, waiting for mem_ack
module mem_port_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflict,
  output logic [15:0]       stat_forced
`endif
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       if_elig;
  logic       dm_elig;
  logic       grant_if;
  logic       grant_dm;

  // Pending-request view and grant decision for the current IDLE cycle
  always_comb begin
    if_elig  = bus.if_req & ~bus.if_ready;
    dm_elig  = bus.dm_req & ~bus.dm_ready;
    grant_if = (state == IDLE) & if_elig & (~dm_elig | (starve_cnt == STARVE_LIM));
    grant_dm = (state == IDLE) & dm_elig & ~grant_if;
  end

  assign bus.stall_if  = if_elig;
  assign bus.stall_mem = dm_elig;

  // Transaction sequencer: grant, hold mem_* until ack, return data and ready pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= 4'd0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.dm_rdata  <= {DATA_W{1'b0}};
      bus.if_ready  <= 1'b0;
      bus.dm_ready  <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= {DATA_W{1'b0}};
            starve_cnt    <= 4'd0;
            state         <= IF_BUSY;
          end else if (grant_dm) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            if (if_elig && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            state <= DM_BUSY;
          end
        end
        IF_BUSY: begin
          if (bus.mem_ack) begin
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.if_rdata <= bus.mem_rdata;
            bus.if_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        DM_BUSY: begin
          if (bus.mem_ack) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (!bus.mem_we) begin
              bus.dm_rdata <= bus.mem_rdata;
            end
            bus.dm_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating counters: tie cycles, and ties resolved in favour of IF by starvation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_conflict <= 16'd0;
      stat_forced   <= 16'd0;
    end else begin
      if ((state == IDLE) && if_elig && dm_elig && (stat_conflict != 16'hFFFF)) begin
        stat_conflict <= stat_conflict + 16'd1;
      end
      if (grant_if && dm_elig && (stat_forced != 16'hFFFF)) begin
        stat_forced <= stat_forced + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;
  localparam int VW         = 6 + ADDR_W + 3 * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stat_conflict;
  logic [15:0] stat_forced;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef ARB_STATS_EN
    .stat_conflict(stat_conflict),
    .stat_forced(stat_forced),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit                m_busy, m_own_if, m_en, m_we, m_if_rdy, m_dm_rdy;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  int                m_starve, m_conflict, m_forced;
  bit                grant_log[$];

  // memory responder
  bit auto_ack = 1'b0;
  int lat      = 0;
  int busy_cyc = 0;

  function automatic void model_reset();
    m_busy = 0; m_own_if = 0; m_en = 0; m_we = 0; m_if_rdy = 0; m_dm_rdy = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    m_starve = 0; m_conflict = 0; m_forced = 0;
  endfunction

  function automatic void model_step();
    bit if_el, dm_el, pick_if;
    pick_if = 1'b0;
    if_el = bus.if_req && !m_if_rdy;
    dm_el = bus.dm_req && !m_dm_rdy;
    m_if_rdy = 0;
    m_dm_rdy = 0;
    if (m_busy) begin
      if (bus.mem_ack) begin
        if (m_own_if) begin
          m_if_rdata = bus.mem_rdata;
          m_if_rdy   = 1;
        end else begin
          if (!m_we) m_dm_rdata = bus.mem_rdata;
          m_dm_rdy = 1;
        end
        m_busy = 0; m_en = 0; m_we = 0;
      end
    end else if (if_el || dm_el) begin
      if (if_el && dm_el) begin
        if (m_conflict < 65535) m_conflict++;
        pick_if = (m_starve == STARVE_MAX);
        if (pick_if && m_forced < 65535) m_forced++;
      end else begin
        pick_if = if_el;
      end
      if (pick_if) m_starve = 0;
      else if (if_el) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      m_busy   = 1;
      m_en     = 1;
      m_own_if = pick_if;
      m_we     = pick_if ? 1'b0 : bus.dm_we;
      m_addr   = pick_if ? bus.if_addr : bus.dm_addr;
      m_wdata  = pick_if ? '0 : bus.dm_wdata;
      grant_log.push_back(pick_if);
    end
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ready, bus.dm_ready,
            bus.if_rdata, bus.dm_rdata, bus.stall_if, bus.stall_mem};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_en, m_we, m_addr, m_wdata, m_if_rdy, m_dm_rdy, m_if_rdata, m_dm_rdata,
            bus.if_req && !m_if_rdy, bus.dm_req && !m_dm_rdy};
  endfunction

  // one clock: advance the model at the edge, then drive the responder at the falling edge
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
    if (auto_ack) begin
      if (m_busy) begin
        bus.mem_ack   = (busy_cyc == lat);
        bus.mem_rdata = $urandom;
        busy_cyc++;
      end else begin
        bus.mem_ack   = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
        busy_cyc      = 0;
        lat           = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready, bus.mem_addr, bus.mem_wdata,
         bus.if_rdata, bus.dm_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got en=%b we=%b ifr=%b dmr=%b addr=%h, required all zero",
               bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready, bus.mem_addr);
    end
    checks++;
    if ({bus.stall_if, bus.stall_mem} !== 2'b10) begin
      errors++;
      $display("FAIL reset_stall: got %b required 10", {bus.stall_if, bus.stall_mem});
    end
    bus.if_req = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_if_read();
    bus.if_req = 1'b1; bus.if_addr = 7'h05; bus.mem_ack = 1'b0;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_addr, bus.stall_if, bus.if_ready} !== {1'b1, 7'h05, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL if_read_issue: got en=%b addr=%h stall=%b rdy=%b required 1 05 1 0",
               bus.mem_en, bus.mem_addr, bus.stall_if, bus.if_ready);
    end
    tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL if_read_wait: got %h required %h", act_vec(), exp_vec());
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    checks++;
    if ({bus.if_ready, bus.if_rdata, bus.mem_en, bus.stall_if} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL if_read_done: got rdy=%b data=%h en=%b stall=%b required 1 12345678 0 0",
               bus.if_ready, bus.if_rdata, bus.mem_en, bus.stall_if);
    end
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    tick();
    checks++;
    if (bus.if_ready !== 1'b0) begin
      errors++;
      $display("FAIL if_read_pulse: got if_ready=%b required 0", bus.if_ready);
    end
  endtask

  task automatic test_dm_store();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 7'h10; bus.dm_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 7'h10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL dm_store_issue: got en=%b we=%b addr=%h wdata=%h required 1 1 10 deadbeef",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5_0F0F;
    tick();
    checks++;
    if ({bus.dm_ready, bus.mem_we, bus.mem_en, bus.dm_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL dm_store_done: got rdy=%b we=%b en=%b rdata=%h required 1 0 0 00000000",
               bus.dm_ready, bus.mem_we, bus.mem_en, bus.dm_rdata);
    end
    bus.mem_ack = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL dm_store_after: got %h required %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 7'h03;
    tick();
    rst = 1'b0;
    bus.dm_req = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.mem_en, bus.dm_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_abort: got en=%b rdy=%b required 0 0", bus.mem_en, bus.dm_ready);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    checks++;
    if ({bus.mem_en, bus.dm_ready, bus.dm_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_late_ack: got en=%b rdy=%b rdata=%h required 0 0 00000000",
               bus.mem_en, bus.dm_ready, bus.dm_rdata);
    end
    bus.mem_ack = 1'b0;
    tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h required %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_drop();
    int pulses;
    pulses = 0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 7'h22;
    tick();
    bus.dm_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.mem_ack = (c == 2); bus.mem_rdata = 32'h0BAD_CAFE;
      tick();
      if (bus.dm_ready === 1'b1) pulses++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_vec c=%0d: got %h required %h", c, act_vec(), exp_vec());
      end
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (pulses !== 1 || bus.dm_rdata !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL drop_pulse: got pulses=%0d rdata=%h required 1 0badcafe", pulses, bus.dm_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit dut_seq[$];
    bit prev_en;
    logic [15:0] got_bits, exp_bits;
    int cyc;
    grant_log.delete();
    prev_en = bus.mem_en;
    bus.if_req = 1'b1; bus.if_addr = 7'h11;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 7'h66;
    auto_ack = 1'b1;
    cyc = 0;
    while (grant_log.size() < 8 && cyc < 300) begin
      tick();
      cyc++;
      if (bus.mem_en && !prev_en) dut_seq.push_back(bus.mem_addr == 7'h11);
      prev_en = bus.mem_en;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_vec cyc=%0d: got %h required %h", cyc, act_vec(), exp_vec());
      end
    end
    got_bits = '0; exp_bits = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < dut_seq.size())   got_bits[i] = dut_seq[i];
      if (i < grant_log.size()) exp_bits[i] = grant_log[i];
    end
    checks++;
    if (grant_log.size() < 8 || dut_seq.size() < 8 || got_bits !== exp_bits) begin
      errors++;
      $display("FAIL b2b_grant_seq: got %b (n=%0d) required %b (n=%0d)",
               got_bits[7:0], dut_seq.size(), exp_bits[7:0], grant_log.size());
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    for (int i = 0; i < 20 && m_busy; i++) tick();
    tick();
    auto_ack = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_random();
    auto_ack = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      bus.if_req   = ($urandom_range(0, 99) < 55);
      bus.if_addr  = ADDR_W'($urandom);
      bus.dm_req   = ($urandom_range(0, 99) < 70);
      bus.dm_we    = $urandom_range(0, 1) == 1;
      bus.dm_addr  = ADDR_W'($urandom);
      bus.dm_wdata = $urandom;
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec c=%0d: got %h required %h", c, act_vec(), exp_vec());
      end
    end
`ifdef ARB_STATS_EN
    checks++;
    if (stat_conflict !== 16'(m_conflict) || stat_forced !== 16'(m_forced)) begin
      errors++;
      $display("FAIL random_stats: got conflict=%0d forced=%0d required %0d %0d",
               stat_conflict, stat_forced, m_conflict, m_forced);
    end
`endif
    auto_ack = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_store();
    test_reset_mid();
    test_drop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
